spi_rx_seq_checker: RTL and testbench

Downstream consumer of the SPI slave receiver's byte strobe (`spi_rxvalid`/`spi_rdata`) in the loopback test design. The master transmit path sends an incrementing byte stream that wraps 255→0. This block checks the received stream for continuity. It acquires and holds lock on the sequence, counts bytes and sequence errors, and flags link stalls with an idle watchdog. It drives the board LEDs with the last received byte.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_rx_idle_timer.sv | 31 +++
 rtl/spi_rx_seq_checker.sv | 140 ++++++++++++++
 tb/tb_spi_rx_seq_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI loopback receive path.
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_rx_idle_timer.sv
// Idle watchdog: counts cycles without a kick while enabled and flags expiry
// on the TIMEOUT_CYCLES-th consecutive idle cycle.
module spi_rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // idle_cnt holds the number of idle cycles already seen, so the current
    // idle cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign expire = enable && !kick && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!enable || kick || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

endmodule

// File: rtl/spi_rx_seq_checker.sv
// Continuity checker for the incrementing SPI loopback byte stream: lock
// tracking, byte/error counters, LED mirror. SPI_RX_CHK_TIMEOUT_EN adds the
// idle watchdog.
module spi_rx_seq_checker
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              err_pulse_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic [7:0]        LED
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

    rx_state_t           state, state_nx;
    logic [DATA_W-1:0]   expected, expected_nx;
    logic [MATCH_W-1:0]  match_cnt, match_nx, match_inc;
    logic                err_nx, timeout_nx;
    logic [CNT_W-1:0]    err_cnt_nx, byte_cnt_nx;
    logic [7:0]          led_nx, led_val;
    logic                hit;
    logic                expire;

    // Fit the received byte onto the 8 board LEDs.
    if (DATA_W >= 8) begin : g_led_trunc
        assign led_val = rx_data_i[7:0];
    end else begin : g_led_ext
        assign led_val = {{(8 - DATA_W){1'b0}}, rx_data_i};
    end

`ifdef SPI_RX_CHK_TIMEOUT_EN
    spi_rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .enable ((state != IDLE) && !clear_i),
        .kick   (rx_valid_i),
        .expire (expire)
    );
`else
    // No watchdog: TIMEOUT_CYCLES has no effect in this build.
    assign expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign hit       = (rx_data_i == expected);
    assign match_inc = MATCH_W'(match_cnt + MATCH_W'(1));

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        match_nx    = match_cnt;
        err_nx      = 1'b0;
        timeout_nx  = 1'b0;
        err_cnt_nx  = err_cnt_o;
        byte_cnt_nx = byte_cnt_o;
        led_nx      = LED;

        if (clear_i) begin
            state_nx    = IDLE;
            expected_nx = '0;
            match_nx    = '0;
            err_cnt_nx  = '0;
            byte_cnt_nx = '0;
            led_nx      = '0;
        end else if (rx_valid_i) begin
            byte_cnt_nx = byte_cnt_o + CNT_W'(1);
            led_nx      = led_val;
            expected_nx = DATA_W'(rx_data_i + DATA_W'(1));
            case (state)
                IDLE: begin
                    state_nx = ACQUIRE;
                    match_nx = MATCH_W'(1);
                end
                ACQUIRE: begin
                    if (hit) begin
                        match_nx = match_inc;
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        match_nx = MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        err_nx   = 1'b1;
                        state_nx = ACQUIRE;
                        match_nx = MATCH_W'(1);
                        if (err_cnt_o != '1) begin
                            err_cnt_nx = err_cnt_o + CNT_W'(1);
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (expire) begin
            state_nx   = IDLE;
            match_nx   = '0;
            timeout_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            expected    <= '0;
            match_cnt   <= '0;
            locked_o    <= 1'b0;
            err_pulse_o <= 1'b0;
            timeout_o   <= 1'b0;
            err_cnt_o   <= '0;
            byte_cnt_o  <= '0;
            LED         <= '0;
        end else begin
            state       <= state_nx;
            expected    <= expected_nx;
            match_cnt   <= match_nx;
            locked_o    <= (state_nx == LOCKED);
            err_pulse_o <= err_nx;
            timeout_o   <= timeout_nx;
            err_cnt_o   <= err_cnt_nx;
            byte_cnt_o  <= byte_cnt_nx;
            LED         <= led_nx;
        end
    end

endmodule

// File: tb/tb_spi_rx_seq_checker.sv
// Self-checking bench for spi_rx_seq_checker (watchdog checks follow SPI_RX_CHK_TIMEOUT_EN).
module tb_spi_rx_seq_checker;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       clear_i;
    logic       locked_o;
    logic       err_pulse_o;
    logic       timeout_o;
    logic [3:0] err_cnt_o;
    logic [3:0] byte_cnt_o;
    logic [7:0] LED;

    spi_rx_seq_checker #(
        .DATA_W         (8),
        .CNT_W          (4),
        .LOCK_COUNT     (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .err_pulse_o (err_pulse_o),
        .timeout_o   (timeout_o),
        .err_cnt_o   (err_cnt_o),
        .byte_cnt_o  (byte_cnt_o),
        .LED         (LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lock;
        logic       err;
        logic       to;
        logic [3:0] ecnt;
        logic [3:0] bcnt;
        logic [7:0] led;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        int         gap;
        exp_t       e;
    } vec_t;

    exp_t  sb[$];
    string sb_tag[$];
    vec_t  tbl[17];
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic exp_t mk(input int lock, input int err, input int to,
                                input int ecnt, input int bcnt, input int led);
        exp_t e;
        e.lock = 1'(lock);
        e.err  = 1'(err);
        e.to   = 1'(to);
        e.ecnt = 4'(ecnt);
        e.bcnt = 4'(bcnt);
        e.led  = 8'(led);
        return e;
    endfunction

    function automatic vec_t vec(input int d, input int gap, input exp_t e);
        vec_t v;
        v.d   = 8'(d);
        v.gap = gap;
        v.e   = e;
        return v;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    function automatic void check_exp(input string tag, input exp_t e);
        chk({tag, ".locked"},   int'(locked_o),    int'(e.lock));
        chk({tag, ".err"},      int'(err_pulse_o), int'(e.err));
        chk({tag, ".timeout"},  int'(timeout_o),   int'(e.to));
        chk({tag, ".err_cnt"},  int'(err_cnt_o),   int'(e.ecnt));
        chk({tag, ".byte_cnt"}, int'(byte_cnt_o),  int'(e.bcnt));
        chk({tag, ".led"},      int'(LED),         int'(e.led));
    endfunction

    // Advance one cycle; compare any result the scoreboard is waiting on.
    task automatic cyc();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check_exp(t, e);
        end
    endtask

    task automatic put(input int d, input logic clr, input exp_t e,
                       input string tag, input bit hold = 1'b0);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'(d);
        clear_i    = clr;
        sb.push_back(e);
        sb_tag.push_back(tag);
        cyc();
        if (!hold) begin
            rx_valid_i = 1'b0;
            clear_i    = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [3:0] bcm, ecm;
        int         last, d;

        tbl[0]  = vec(1,   9, mk(0, 0, 0, 0, 1,  1));
        tbl[1]  = vec(2,   9, mk(0, 0, 0, 0, 2,  2));
        tbl[2]  = vec(3,   9, mk(0, 0, 0, 0, 3,  3));
        tbl[3]  = vec(4,   9, mk(1, 0, 0, 0, 4,  4));
        tbl[4]  = vec(5,   1, mk(1, 0, 0, 0, 5,  5));
        tbl[5]  = vec(9,   1, mk(0, 1, 0, 1, 6,  9));
        tbl[6]  = vec(10,  1, mk(0, 0, 0, 1, 7,  10));
        tbl[7]  = vec(11,  1, mk(0, 0, 0, 1, 8,  11));
        tbl[8]  = vec(12,  1, mk(1, 0, 0, 1, 9,  12));
        tbl[9]  = vec(250, 1, mk(0, 1, 0, 2, 10, 250));
        tbl[10] = vec(251, 1, mk(0, 0, 0, 2, 11, 251));
        tbl[11] = vec(252, 1, mk(0, 0, 0, 2, 12, 252));
        tbl[12] = vec(253, 1, mk(1, 0, 0, 2, 13, 253));
        tbl[13] = vec(254, 1, mk(1, 0, 0, 2, 14, 254));
        tbl[14] = vec(255, 1, mk(1, 0, 0, 2, 15, 255));
        tbl[15] = vec(0,   1, mk(1, 0, 0, 2, 0,  0));
        tbl[16] = vec(1,   1, mk(1, 0, 0, 2, 1,  1));

        rst        = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        clear_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_exp("reset", mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        cyc();

        // Lock, error/relock and 255->0 wrap sequence.
        for (int i = 0; i < 17; i++) begin
            put(int'(tbl[i].d), 1'b0, tbl[i].e, $sformatf("vec%0d", i));
            cyc();
            chk($sformatf("vec%0d.err_drop", i), int'(err_pulse_o), 0);
            for (int g = 1; g < tbl[i].gap; g++) cyc();
        end

`ifdef SPI_RX_CHK_TIMEOUT_EN
        put(2, 1'b0, mk(1, 0, 0, 2, 2, 2), "pre_to");
        for (int k = 1; k <= int'(T) + 2; k++) begin
            cyc();
            chk($sformatf("to_wait%0d", k), int'(timeout_o), int'(k == int'(T)));
            if (k == int'(T)) chk("to_unlock", int'(locked_o), 0);
        end
        put(5, 1'b0, mk(0, 0, 0, 2, 3, 5), "post_to");
        for (int m = 1; m < int'(T); m++) begin
            cyc();
            chk($sformatf("edge_wait%0d", m), int'(timeout_o), 0);
        end
        put(6, 1'b0, mk(0, 0, 0, 2, 4, 6), "edge_valid");
        for (int k = 1; k <= int'(T) + 1; k++) begin
            cyc();
            chk($sformatf("to2_wait%0d", k), int'(timeout_o), int'(k == int'(T)));
        end
`else
        for (int k = 1; k <= 2 * int'(T) + 2; k++) begin
            cyc();
            chk($sformatf("no_to%0d", k), int'(timeout_o), 0);
        end
        chk("no_to.locked", int'(locked_o), 1);
`endif

        // Clear beats a coincident valid; the byte is dropped.
        put(77, 1'b1, mk(0, 0, 0, 0, 0, 0), "clear");
        cyc();
        chk("clear.hold_bcnt", int'(byte_cnt_o), 0);

        // Mismatch in ACQUIRE restarts the match run without an error.
        put(1,  1'b0, mk(0, 0, 0, 0, 1, 1),  "acq1");  cyc();
        put(2,  1'b0, mk(0, 0, 0, 0, 2, 2),  "acq2");  cyc();
        put(7,  1'b0, mk(0, 0, 0, 0, 3, 7),  "acq7");  cyc();
        put(8,  1'b0, mk(0, 0, 0, 0, 4, 8),  "acq8");  cyc();
        put(9,  1'b0, mk(0, 0, 0, 0, 5, 9),  "acq9");  cyc();
        put(10, 1'b0, mk(1, 0, 0, 0, 6, 10), "acq10"); cyc();

        // Asynchronous reset in ACQUIRE, just after an error.
        put(50, 1'b0, mk(0, 1, 0, 1, 7, 50), "pre_rst");
        #2 rst = 1'b1;
        #1 check_exp("rst_mid", mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check_exp("rst_after", mk(0, 0, 0, 0, 0, 0));

        // Back-to-back stream: lock, then 20 mismatch+relock rounds.
        bcm = '0;
        ecm = '0;
        for (int i = 1; i <= 4; i++) begin
            bcm++;
            put(i, 1'b0, mk(int'(i == 4), 0, 0, 0, int'(bcm), i), $sformatf("sat_lock%0d", i), 1'b1);
        end
        last = 4;
        for (int it = 0; it < 20; it++) begin
            d = (last + 3) & 255;
            if (ecm != 4'hF) ecm++;
            bcm++;
            put(d, 1'b0, mk(0, 1, 0, int'(ecm), int'(bcm), d), $sformatf("sat%0d_err", it), 1'b1);
            for (int j = 1; j <= 3; j++) begin
                bcm++;
                put((d + j) & 255, 1'b0, mk(int'(j == 3), 0, 0, int'(ecm), int'(bcm), (d + j) & 255),
                    $sformatf("sat%0d_re%0d", it, j), 1'b1);
            end
            last = (d + 3) & 255;
        end
        rx_valid_i = 1'b0;
        cyc();
        chk("sat.err_cnt", int'(err_cnt_o), 15);
        chk("sat.err_drop", int'(err_pulse_o), 0);
        chk("sat.locked", int'(locked_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
